// File: rtl/dmem_stream_pkg.sv
// Shared types and constants for the data-memory stream reader.
// The FSM state encoding and the FIFO entry layout live here.
package dmem_stream_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        DRAIN,
        FIN
    } state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/dmem_stream_reader_if.sv
// Bundles the data-memory bus port and the output stream of the reader.
// master = reader engine, slave = memory/arbiter plus output sink.
interface dmem_stream_reader_if;

    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output bus_req, mem_addr, out_valid, out_data, out_last,
        input  bus_gnt, mem_rdata, out_ready
    );

    modport slave (
        input  bus_req, mem_addr, out_valid, out_data, out_last,
        output bus_gnt, mem_rdata, out_ready
    );

endinterface

// File: rtl/stream_fifo.sv
// Synchronous FIFO for the output stream; pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter.
module stream_fifo
    import dmem_stream_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push_en;
    logic          pop_en;

    // Full is judged on the pre-pop state, so a push into a full FIFO is
    // refused even when a pop happens on the same edge.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; resetting the pointers flushes the FIFO
    // and keeps the array mappable onto plain RAM/flops without reset.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dmem_stream_reader.sv
// Read engine: on start, requests the data-memory port, walks a word-aligned
// region and streams the words out through a small FIFO, tagging the last.
module dmem_stream_reader
    import dmem_stream_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           base_addr,
    input  logic [CNT_W-1:0]      word_count,
    output logic                  busy,
    output logic                  done,
    dmem_stream_reader_if.master  bus
);

    state_t             state;
    logic [31:0]        cur_addr;
    logic [CNT_W-1:0]   remaining;
    logic [31:0]        mem_addr_q;
    logic               bus_req_q;

    fifo_entry_t        push_data;
    fifo_entry_t        head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               beat;
    logic               is_last;

    assign is_last   = (remaining == CNT_W'(1));
    assign beat      = (state == READ) && bus.bus_gnt && !fifo_full;
    assign push_data = '{last: is_last, data: bus.mem_rdata};

    stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (beat),
        .push_data (push_data),
        .pop       (bus.out_valid && bus.out_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head fields are masked while empty so the outputs read 0 after reset.
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : head.data;
    assign bus.out_last  = !fifo_empty && head.last;
    assign bus.bus_req   = bus_req_q;
    assign bus.mem_addr  = mem_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            mem_addr_q <= '0;
            bus_req_q  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            cur_addr  <= base_addr & ~32'd3;
                            remaining <= word_count;
                            bus_req_q <= 1'b1;
                            busy      <= 1'b1;
                            state     <= REQ;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_gnt) begin
                        mem_addr_q <= cur_addr;
                        state      <= READ;
                    end
                end
                READ: begin
                    if (!bus.bus_gnt) begin
                        state <= REQ;
                    end else if (!fifo_full) begin
                        cur_addr  <= cur_addr + 32'(WORD_BYTES);
                        remaining <= remaining - CNT_W'(1);
                        if (is_last) begin
                            bus_req_q <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            // Address runs one word ahead so mem_rdata is valid for the next beat.
                            mem_addr_q <= cur_addr + 32'(WORD_BYTES);
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_stream_reader.sv
// Directed bench for dmem_stream_reader: combinational memory model,
// output monitor on the falling edge, hand-computed expected streams.
module tb_dmem_stream_reader;
    import dmem_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [11:0] word_count;
    logic        busy;
    logic        done;

    dmem_stream_reader_if bif();

    dmem_stream_reader #(
        .CNT_W      (12),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .bus        (bif.master)
    );

    always #5 clk = ~clk;

    // Memory contents: word at byte address a holds ((a>>2)+1)*11.
    function automatic logic [31:0] mem_model(input logic [31:0] addr);
        logic [31:0] w;
        w = {2'b00, addr[31:2]} + 32'd1;
        return w * 32'd11;
    endfunction

    assign bif.mem_rdata = mem_model(bif.mem_addr);

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    bit          req_seen = 0;
    bit          valid_seen = 0;
    logic [32:0] rx_q[$];
    int          rx_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bif.out_valid && bif.out_ready) begin
                rx_q.push_back({bif.out_last, bif.out_data});
                rx_cyc.push_back(cyc);
            end
            if (done)          done_cnt++;
            if (bif.bus_req)   req_seen = 1'b1;
            if (bif.out_valid) valid_seen = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rx_q.delete();
        rx_cyc.delete();
        done_cnt   = 0;
        req_seen   = 1'b0;
        valid_seen = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic [11:0] cnt);
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("done_seen", 32'(seen), 32'd1);
        tick();
    endtask

    task automatic check_stream(input logic [31:0] base, input int n);
        check("rx_count", 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            check($sformatf("word%0d_data", i), rx_q[i][31:0], mem_model(base + 32'(4 * i)));
            check($sformatf("word%0d_last", i), 32'(rx_q[i][32]), 32'(i == n - 1));
        end
        check("done_count", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        base_addr     = '0;
        word_count    = '0;
        bif.bus_gnt   = 1'b0;
        bif.out_ready = 1'b0;
        repeat (3) tick();

        check("rst_busy",      32'(busy),          32'd0);
        check("rst_done",      32'(done),          32'd0);
        check("rst_bus_req",   32'(bif.bus_req),   32'd0);
        check("rst_out_valid", 32'(bif.out_valid), 32'd0);
        check("rst_out_last",  32'(bif.out_last),  32'd0);
        check("rst_mem_addr",  bif.mem_addr,       32'd0);
        rst_n = 1'b1;
        tick();

        // Basic read of four words at 0x0.
        clear_mon();
        bif.bus_gnt   = 1'b1;
        bif.out_ready = 1'b1;
        pulse_start(32'h0, 12'd4);
        check("basic_bus_req", 32'(bif.bus_req), 32'd1);
        check("basic_busy",    32'(busy),        32'd1);
        tick();
        check("basic_addr0",   bif.mem_addr,     32'h0);
        wait_done(30);
        check("basic_n", 32'(rx_q.size()), 32'd4);
        if (rx_q.size() == 4) begin
            check("basic_w0", rx_q[0][31:0], 32'd11);
            check("basic_w1", rx_q[1][31:0], 32'd22);
            check("basic_w2", rx_q[2][31:0], 32'd33);
            check("basic_w3", rx_q[3][31:0], 32'd44);
            check("basic_lastflags", 32'({rx_q[0][32], rx_q[1][32], rx_q[2][32], rx_q[3][32]}), 32'b0001);
            check("basic_consecutive", 32'(rx_cyc[3] - rx_cyc[0]), 32'd3);
        end
        check("basic_done_cnt", 32'(done_cnt), 32'd1);
        check("basic_busy_end", 32'(busy), 32'd0);

        // Unaligned base is forced down to a word boundary.
        clear_mon();
        pulse_start(32'h7, 12'd2);
        tick();
        check("unal_addr0", bif.mem_addr, 32'h4);
        wait_done(30);
        check_stream(32'h4, 2);

        // Zero count: done next cycle, no bus request, no output.
        clear_mon();
        pulse_start(32'h40, 12'd0);
        check("zero_done",  32'(done), 32'd1);
        check("zero_busy",  32'(busy), 32'd0);
        tick();
        check("zero_done_clr", 32'(done), 32'd0);
        tick();
        check("zero_req_seen",   32'(req_seen),   32'd0);
        check("zero_valid_seen", 32'(valid_seen), 32'd0);
        check("zero_done_cnt",   32'(done_cnt),   32'd1);

        // Grant loss for 3 cycles after two beats.
        clear_mon();
        pulse_start(32'h100, 12'd6);
        tick();
        check("gnt_addr0", bif.mem_addr, 32'h100);
        tick();
        tick();
        bif.bus_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gnt_hold_addr", bif.mem_addr, 32'h108);
            check("gnt_hold_req",  32'(bif.bus_req), 32'd1);
        end
        check("gnt_words_in_gap", 32'(rx_q.size()), 32'd2);
        bif.bus_gnt = 1'b1;
        tick();
        check("gnt_resume_addr", bif.mem_addr, 32'h108);
        wait_done(40);
        check_stream(32'h100, 6);

        // Backpressure: only FIFO_DEPTH beats, then stall with stable head.
        clear_mon();
        bif.out_ready = 1'b0;
        pulse_start(32'h200, 12'd8);
        repeat (10) tick();
        check("bp_bus_req",   32'(bif.bus_req),   32'd1);
        check("bp_mem_addr",  bif.mem_addr,       32'h210);
        check("bp_out_valid", 32'(bif.out_valid), 32'd1);
        check("bp_out_data",  bif.out_data,       mem_model(32'h200));
        tick();
        check("bp_out_data_stable", bif.out_data, mem_model(32'h200));
        check("bp_out_last",  32'(bif.out_last),  32'd0);
        bif.out_ready = 1'b1;
        wait_done(40);
        check_stream(32'h200, 8);

        // Address wrap across the top of the address space.
        clear_mon();
        pulse_start(32'hFFFF_FFF8, 12'd3);
        tick();
        check("wrap_a0", bif.mem_addr, 32'hFFFF_FFF8);
        tick();
        check("wrap_a1", bif.mem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_a2", bif.mem_addr, 32'h0000_0000);
        wait_done(30);
        check_stream(32'hFFFF_FFF8, 3);

        // Reset in the middle of a transfer, then a fresh start.
        clear_mon();
        pulse_start(32'h300, 12'd5);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",      32'(busy),          32'd0);
        check("mid_rst_bus_req",   32'(bif.bus_req),   32'd0);
        check("mid_rst_out_valid", 32'(bif.out_valid), 32'd0);
        check("mid_rst_out_last",  32'(bif.out_last),  32'd0);
        check("mid_rst_out_data",  bif.out_data,       32'd0);
        check("mid_rst_mem_addr",  bif.mem_addr,       32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
        check("post_rst_empty", 32'(bif.out_valid), 32'd0);
        pulse_start(32'h400, 12'd2);
        tick();
        check("post_rst_addr0", bif.mem_addr, 32'h400);
        wait_done(30);
        check_stream(32'h400, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
